// File: rtl/nice_deque_engine_pkg.sv
// nice_deque_engine_pkg: opcodes, status codes and response FSM states for the deque engine.
package nice_deque_engine_pkg;
  localparam int OP_W = 3;
  localparam int STATUS_W = 2;
  typedef enum logic [OP_W-1:0] {PUSH_BACK, PUSH_FRONT, POP_FRONT, POP_BACK, GET, CLEAR} op_e;
  typedef enum logic [STATUS_W-1:0] {OK, EMPTY, FULL, OOB} status_e;
  typedef enum logic {S_IDLE, S_RESP} state_e;
endpackage

// File: rtl/nice_ring_store.sv
// nice_ring_store: DEPTH x WIDTH register array, one write port, one combinational read port.
module nice_ring_store #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/nice_deque_engine.sv
// nice_deque_engine: double-ended queue with push/pop at both ends, indexed get, registered response.
module nice_deque_engine
  import nice_deque_engine_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OP_W-1:0]     cmd_op,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [IDX_W-1:0]    cmd_index,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data,
  output logic [STATUS_W-1:0] rsp_status,
  output logic [CNT_W-1:0]    count,
  output logic                empty,
  output logic                full
);
  state_e state, n_state;
  status_e status, n_status;
  op_e op;
  logic [IDX_W-1:0] head, n_head, waddr, raddr, cnt_i;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [WIDTH-1:0] rdata, n_data;
  logic accept, take, push, we;
  assign op = op_e'(cmd_op);
  assign rsp_valid = state == S_RESP;
  assign cmd_ready = !rsp_valid || rsp_ready;
  assign accept = cmd_valid && cmd_ready;
  assign take = rsp_valid && rsp_ready;
  assign count = cnt;
  assign empty = cnt == '0;
  assign full = cnt == CNT_W'(DEPTH);
  assign rsp_status = status;
  assign cnt_i = cnt[IDX_W-1:0];
  assign push = op == PUSH_BACK || op == PUSH_FRONT;
  assign we = accept && push && !full;
  // Addresses wrap modulo DEPTH through the natural IDX_W overflow.
  assign waddr = op == PUSH_FRONT ? head - IDX_W'(1) : head + cnt_i;
  assign raddr = op == POP_BACK ? head + cnt_i - IDX_W'(1) : op == GET ? head + cmd_index : head;
  nice_ring_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_store (
    .clk(clk), .we(we), .waddr(waddr), .wdata(cmd_data), .raddr(raddr), .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= n_state;
  always_comb begin
    n_state = state;
    if (accept) n_state = S_RESP;
    else if (take) n_state = S_IDLE;
  end
  always_comb begin
    n_head = head;
    n_cnt = cnt;
    n_data = '0;
    n_status = OK;
    case (op)
      PUSH_BACK, PUSH_FRONT:
        if (full) n_status = FULL;
        else begin
          n_head = op == PUSH_FRONT ? head - IDX_W'(1) : head;
          n_cnt = cnt + CNT_W'(1);
        end
      POP_FRONT, POP_BACK:
        if (empty) n_status = EMPTY;
        else begin
          n_data = rdata;
          n_head = op == POP_FRONT ? head + IDX_W'(1) : head;
          n_cnt = cnt - CNT_W'(1);
        end
      GET:
        if (CNT_W'(cmd_index) >= cnt) n_status = OOB;
        else n_data = rdata;
      CLEAR: begin
        n_head = '0;
        n_cnt = '0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      cnt <= '0;
      rsp_data <= '0;
      status <= OK;
    end else if (accept) begin
      head <= n_head;
      cnt <= n_cnt;
      rsp_data <= n_data;
      status <= n_status;
    end
endmodule
